// File: rtl/spi_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_pkg
// Description : Shared definitions for the SPI memory master: frame geometry,
//               FSM state encoding and the frame-assembly helper.
// Contents    : FRAME_BITS, ADDR_BITS, DATA_BITS, spi_state_e, build_frame()
// Revision    : 1.0 - initial release
// ============================================================================
package spi_master_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_BITS  = 7;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_SCLK_HI = 3'd2,
        ST_SCLK_LO = 3'd3,
        ST_TAIL    = 3'd4,
        ST_GAP     = 3'd5
    } spi_state_e;

    // Command byte {addr, rw} followed by the write data, or by zeros for a
    // read so the memory sees a quiet line while it drives miso.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [ADDR_BITS-1:0] addr,
        input logic                 rw,
        input logic [DATA_BITS-1:0] wdata
    );
        return {addr, rw, (rw ? {DATA_BITS{1'b0}} : wdata)};
    endfunction

endpackage : spi_master_pkg
`default_nettype wire

// File: rtl/sclk_divider.sv
`default_nettype none
// ============================================================================
// Module      : sclk_divider
// Description : Phase timer for the SPI master. Counts HALF_PERIOD cycles per
//               phase (2*HALF_PERIOD when i_long_phase is set) and flags the
//               last cycle of the phase. Restarts from zero on i_restart.
// Ports       : clk, rst          - clock / synchronous active-high reset
//               i_enable          - timer runs only while a frame is active
//               i_restart         - the FSM changes state this cycle
//               i_long_phase      - current phase is double length
//               o_phase_end       - last cycle of the current phase
// Revision    : 1.0 - initial release
// ============================================================================
module sclk_divider #(
    parameter int HALF_PERIOD = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    input  logic i_restart,
    input  logic i_long_phase,
    output logic o_phase_end
);

    localparam int c_cnt_w = $clog2(2 * HALF_PERIOD);
    localparam logic [c_cnt_w-1:0] c_short_last = c_cnt_w'(HALF_PERIOD - 1);
    localparam logic [c_cnt_w-1:0] c_long_last  = c_cnt_w'(2 * HALF_PERIOD - 1);
    localparam logic [c_cnt_w-1:0] c_one        = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;

    // Counter value 0 is always the first cycle of a phase, because the
    // restart pulse coincides with the edge that enters the new state.
    always_ff @(posedge clk) begin
        if (rst || !i_enable || i_restart) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_one;
        end
    end

    assign o_phase_end = i_enable &&
                         (r_cnt == (i_long_phase ? c_long_last : c_short_last));

endmodule : sclk_divider
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_master
// Description : SPI mode-0 master for a word-addressed serial memory. Sends a
//               16-bit frame {addr, rw, wdata|0} MSB first, captures the read
//               byte from miso, then holds cs high for a 2*HALF_PERIOD gap.
// Ports       : clk, reset        - clock / synchronous active-high reset
//               start, rw, addr, wdata - request, latched when accepted in IDLE
//               busy, done        - transaction in flight / end-of-frame pulse
//               rdata             - last byte read, held between reads
//               sclk_pin, cs_pin, mosi_pin, miso_pin - SPI pins
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master
    import spi_master_pkg::*;
#(
    parameter int HALF_PERIOD = 50   // clk cycles per sclk half-period, >= 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 rw,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 sclk_pin,
    output logic                 cs_pin,
    output logic                 mosi_pin,
    input  logic                 miso_pin
);

    localparam logic [3:0] c_last_bit  = 4'(FRAME_BITS - 1);
    localparam logic [3:0] c_first_rd  = 4'(FRAME_BITS - DATA_BITS);

    spi_state_e              r_state;
    spi_state_e              w_state_next;
    logic [FRAME_BITS-1:0]   r_frame;
    logic [3:0]              r_bit_cnt;
    logic                    r_rw;
    logic [DATA_BITS-1:0]    r_cap;
    logic [DATA_BITS-1:0]    r_rdata;
    logic                    r_done;

    logic w_phase_end;
    logic w_accept;
    logic w_restart;
    logic w_enable;
    logic w_long_phase;
    logic w_hi_end;
    logic w_sample;
    logic w_in_frame;

    // The done cycle is spent in IDLE; blocking acceptance there keeps a start
    // that coincides with done from launching a new frame.
    assign w_accept     = (r_state == ST_IDLE) && start && !r_done;
    assign w_enable     = (r_state != ST_IDLE);
    assign w_long_phase = (r_state == ST_GAP);
    assign w_restart    = (w_state_next != r_state);
    assign w_hi_end     = (r_state == ST_SCLK_HI) && w_phase_end;

    // During the low phase that precedes rising edge k the bit counter holds
    // k-1, so counts 8..15 select the low phases before edges 9..16.
    assign w_sample = r_rw && (r_state == ST_SCLK_LO) && w_phase_end &&
                      (r_bit_cnt >= c_first_rd);

    sclk_divider #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_sclk_divider (
        .clk          (clk),
        .rst          (reset),
        .i_enable     (w_enable),
        .i_restart    (w_restart),
        .i_long_phase (w_long_phase),
        .o_phase_end  (w_phase_end)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_accept)    w_state_next = ST_SETUP;
            ST_SETUP:   if (w_phase_end) w_state_next = ST_SCLK_HI;
            ST_SCLK_HI: if (w_phase_end) w_state_next = (r_bit_cnt == c_last_bit) ?
                                                        ST_TAIL : ST_SCLK_LO;
            ST_SCLK_LO: if (w_phase_end) w_state_next = ST_SCLK_HI;
            ST_TAIL:    if (w_phase_end) w_state_next = ST_GAP;
            ST_GAP:     if (w_phase_end) w_state_next = ST_IDLE;
            default:                     w_state_next = ST_IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame   <= '0;
            r_bit_cnt <= '0;
            r_rw      <= 1'b0;
            r_cap     <= '0;
            r_rdata   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == ST_GAP) && w_phase_end;

            if (w_accept) begin
                r_frame   <= build_frame(addr, rw, wdata);
                r_rw      <= rw;
                r_bit_cnt <= '0;
                r_cap     <= '0;
            end

            // Leaving a high phase: the next bit appears on mosi in the
            // first cycle of the following low phase. The last high phase
            // leaves the counter at 15 so it never wraps.
            if (w_hi_end && (r_bit_cnt != c_last_bit)) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
                r_frame   <= {r_frame[FRAME_BITS-2:0], 1'b0};
            end

            if (w_sample) begin
                r_cap <= {r_cap[DATA_BITS-2:0], miso_pin};
            end

            if ((r_state == ST_GAP) && w_phase_end && r_rw) begin
                r_rdata <= r_cap;
            end
        end
    end

    // ------------------------------------------------------------ outputs
    assign w_in_frame = (r_state == ST_SETUP) || (r_state == ST_SCLK_HI) ||
                        (r_state == ST_SCLK_LO);

    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign rdata    = r_rdata;
    assign sclk_pin = (r_state == ST_SCLK_HI);
    assign cs_pin   = !(w_in_frame || (r_state == ST_TAIL));
    assign mosi_pin = w_in_frame ? r_frame[FRAME_BITS-1] : 1'b0;

endmodule : spi_master
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master
// Description : Self-checking bench for spi_master with a behavioural SPI
//               memory on the pins. Table of write/read transactions plus
//               hand-written sequences for busy/done/reset corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    localparam int H        = 4;
    localparam int DONE_CYC = 35 * H + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       sclk_pin;
    logic       cs_pin;
    logic       mosi_pin;
    logic       m_miso = 1'b0;

    always #5 clk = ~clk;

    spi_master #(
        .HALF_PERIOD (H)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rw       (rw),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .sclk_pin (sclk_pin),
        .cs_pin   (cs_pin),
        .mosi_pin (mosi_pin),
        .miso_pin (m_miso)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------ SPI memory model
    logic [7:0]  mem [0:127];
    int          m_cnt = 0;
    logic [15:0] m_bits = '0;
    logic        m_rw = 1'b0;
    logic [6:0]  m_addr = '0;
    logic        m_unstable = 1'b0;
    logic        m_prev_sclk = 1'b0;
    logic        m_prev_cs = 1'b1;
    logic [7:0]  m_byte;

    always @(negedge clk) begin
        if (!cs_pin && m_prev_cs) begin
            m_cnt = 0; m_bits = '0; m_unstable = 1'b0; m_rw = 1'b0; m_miso = 1'b0;
        end
        if (!cs_pin) begin
            if (sclk_pin && !m_prev_sclk) begin
                m_bits = {m_bits[14:0], mosi_pin};
                m_cnt++;
                if (m_cnt == 8) begin
                    m_rw = m_bits[0]; m_addr = m_bits[7:1];
                end
                if (m_cnt == 16 && !m_bits[8]) mem[m_bits[15:9]] = m_bits[7:0];
            end else if (sclk_pin && (mosi_pin !== m_bits[0])) begin
                m_unstable = 1'b1;
            end
            if (!sclk_pin && m_prev_sclk && m_rw && m_cnt >= 8 && m_cnt <= 15) begin
                m_byte = mem[m_addr];
                m_miso = m_byte[15 - m_cnt];
            end
        end
        m_prev_sclk = sclk_pin;
        m_prev_cs   = cs_pin;
    end

    // ------------------------------------------------ pin monitors
    int done_cnt = 0;
    int cs_run = 0;
    int min_gap = 100000;
    bit fall_seen = 0;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (cs_pin) begin
            cs_run++;
        end else begin
            if (cs_run > 0 && fall_seen && cs_run < min_gap) min_gap = cs_run;
            if (cs_run > 0) fall_seen = 1;
            cs_run = 0;
        end
    end

    // ------------------------------------------------ one transaction
    task automatic run_txn(input logic t_rw, input logic [6:0] t_addr, input logic [7:0] t_wdata,
                           input logic [15:0] exp_frame, input int intr_cycle);
        int n;
        bit seen;
        @(negedge clk);
        rw = t_rw; addr = t_addr; wdata = t_wdata; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        seen = 0;
        while (!seen && n < DONE_CYC + 50) begin
            @(negedge clk);
            n++;
            if (n == 1)
                check("setup_pins", {cs_pin, sclk_pin, mosi_pin, busy},
                      {1'b0, 1'b0, exp_frame[15], 1'b1});
            if (done) begin
                seen = 1;
                check("busy_at_done", busy, 0);
            end else if (n == intr_cycle) begin
                rw = ~t_rw; addr = ~t_addr; wdata = ~t_wdata; start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        check("done_cycle", n, DONE_CYC);
        check("mosi_frame", m_bits, exp_frame);
        check("sclk_rises", m_cnt, 16);
        check("mosi_stable", m_unstable, 0);
    endtask

    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  wdata;
        logic [15:0] exp_frame;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs [7];
    int   base;
    int   n;

    initial begin
        vecs[0] = '{1'b0, 7'h01, 8'h55, 16'h0255, 8'h00};
        vecs[1] = '{1'b1, 7'h01, 8'h00, 16'h0300, 8'h55};
        vecs[2] = '{1'b1, 7'h22, 8'h00, 16'h4500, 8'hA3};
        vecs[3] = '{1'b0, 7'h7F, 8'h0F, 16'hFE0F, 8'hA3};
        vecs[4] = '{1'b1, 7'h7F, 8'h00, 16'hFF00, 8'h0F};
        vecs[5] = '{1'b0, 7'h00, 8'hFF, 16'h00FF, 8'h0F};
        vecs[6] = '{1'b1, 7'h00, 8'h00, 16'h0100, 8'hFF};

        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[7'h22] = 8'hA3;

        reset = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Idle after reset
        repeat (100) @(negedge clk);
        check("idle_cs", cs_pin, 1);
        check("idle_sclk", sclk_pin, 0);
        check("idle_mosi", mosi_pin, 0);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_rdata", rdata, 8'h00);

        // Table of back-to-back transactions
        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp_frame, 0);
            check($sformatf("rdata_v%0d", i), rdata, vecs[i].exp_rdata);
        end
        check("min_cs_gap", (min_gap >= 2 * H), 1);

        // Start pulsed while busy: ignored, inputs not re-latched
        @(negedge clk);
        base = done_cnt;
        run_txn(1'b0, 7'h05, 8'h3C, 16'h0A3C, 20);
        check("rdata_after_intr_write", rdata, 8'hFF);
        // Start coincident with done: ignored
        rw = 1'b1; addr = 7'h05; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("start_at_done_ignored", {busy, cs_pin}, 2'b01);
        check("single_done", done_cnt - base, 1);
        run_txn(1'b1, 7'h05, 8'h00, 16'h0B00, 0);
        check("rdata_read_05", rdata, 8'h3C);

        // Reset after the 5th sclk rising edge aborts the frame
        @(negedge clk);
        rw = 1'b1; addr = 7'h22; wdata = 8'h00; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (m_cnt != 5 && n < 400) begin
            @(posedge clk);
            n++;
        end
        check("reach_rise5", (n < 400), 1);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_pins", {cs_pin, sclk_pin, busy}, 3'b100);
        check("abort_rdata", rdata, 8'h00);
        base = done_cnt;
        repeat (DONE_CYC + 20) @(negedge clk);
        check("no_done_after_abort", done_cnt - base, 0);
        run_txn(1'b1, 7'h22, 8'h00, 16'h4500, 0);
        check("rdata_after_abort", rdata, 8'hA3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_spi_master
`default_nettype wire

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter HALF_PERIOD, default 50, clk cycles per sclk half-period; legal range >= 4.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a transaction.
REQ-005 rw  input  1  1 = read, 0 = write; latched at start.
REQ-006 addr  input  7  target word address; latched at start.
REQ-007 wdata  input  8  write data; latched at start.
REQ-008 busy  output  1  high from the cycle after an accepted start until done.
REQ-009 done  output  1  one-cycle pulse at transaction end.
REQ-010 rdata  output  8  last read byte; held until the next read completes.
REQ-011 sclk_pin  output  1  serial clock; idles low.
REQ-012 cs_pin  output  1  active-low chip select; idles high.
REQ-013 mosi_pin  output  1  serial data to the memory, MSB first.
REQ-014 miso_pin  input  1  serial data from the memory; may be Z outside the read data phase.

Function
REQ-015 start is accepted only in IDLE; start while busy is ignored, and addr, rw and wdata are not re-latched.
REQ-016 Frame is 16 bits, MSB first: {addr[6:0], rw} followed by wdata[7:0] for a write, or by eight 0 bits for a read.
REQ-017 States: IDLE, SETUP, SCLK_HI, SCLK_LO, TAIL, GAP; every state except IDLE lasts exactly HALF_PERIOD cycles, except GAP, which lasts 2*HALF_PERIOD.
REQ-018 Timing reference: an accepted start is sampled at edge 0; cs_pin=0, sclk_pin=0, mosi_pin=frame[15] from cycle 1 (SETUP).
REQ-019 SETUP -> SCLK_HI (sclk_pin=1) -> SCLK_LO (sclk_pin=0; mosi_pin advances to the next frame bit on the SCLK_LO entry cycle) -> SCLK_HI, repeated until 16 high phases are done.
REQ-020 mosi_pin is stable for the whole of each high phase; the memory samples on the sclk rising edge.
REQ-021 Read: miso_pin is sampled on the last cycle of each of the 8 low phases that precede rising edges 9..16; it is shifted MSB first into a capture register.
REQ-022 After the 16th high phase: TAIL with sclk_pin=0 and cs_pin=0, then GAP with cs_pin=1, sclk_pin=0, mosi_pin=0.
REQ-023 At the end of GAP: done=1 for one cycle, busy=0 in that same cycle, and the FSM returns to IDLE; done occurs in cycle 35*HALF_PERIOD+1.
REQ-024 rdata is updated from the capture register in the done cycle, for reads only; a write leaves rdata unchanged.
REQ-025 A start coincident with done is ignored; a new start is accepted from the cycle after done.
REQ-026 Bit counter is 4 bits and counts 0..15; it never wraps mid-frame.

Reset
REQ-027 While reset=1 at an edge: state=IDLE, cs_pin=1, sclk_pin=0, mosi_pin=0, busy=0, done=0, rdata=8'h00, and the counters and capture register are cleared.
REQ-028 Reset mid-transaction aborts it: cs_pin is high the next cycle, no done pulse is produced, and rdata=0.
REQ-029 reset has priority over start in the same cycle.

Structure
REQ-030 The shared package holds the state encoding and the constants FRAME_BITS=16, ADDR_BITS=7 and DATA_BITS=8.
REQ-031 One sub-module, sclk_divider, is the HALF_PERIOD phase timer; it issues a phase_end pulse and restarts on each state change.

Verification
REQ-032 Reset, then idle for 100 cycles -> cs_pin=1, sclk_pin=0, mosi_pin=0, busy=0, done=0, rdata=00.
REQ-033 Write addr=7'h01, wdata=8'h55 -> mosi_pin at the 16 rising edges = 0000001_0_01010101; done at cycle 35*HALF_PERIOD+1; rdata unchanged.
REQ-034 Paired with the SPI memory, write 0x55 to addr 1, then read addr 1 -> read frame bits 0000001_1 then 0s; rdata=8'h55.
REQ-035 A miso model drives 0xA3 on sclk falling edges, then a read runs -> rdata=8'hA3; a subsequent write leaves rdata=8'hA3.
REQ-036 A second start pulsed while busy is ignored (exactly one done); cs_pin stays high for >= 2*HALF_PERIOD between back-to-back transactions.
REQ-037 reset is asserted after the 5th sclk rising edge -> next cycle cs_pin=1, sclk_pin=0, busy=0; no done pulse; a new start then completes normally.
